// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator: 50 MHz clk, divide-by-2 pixel enable, 5x5-cell framebuffer coordinates.
// Define VGA_TEST_PATTERN_EN to add pat_red/pat_green/pat_blue colour-bar outputs for bring-up.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SCALE     = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic       display_en,
  output logic       new_line,
  output logic       new_frame,
  output logic [6:0] hpixel,
  output logic [6:0] vpixel
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic       pat_red,
  output logic       pat_green,
  output logic       pat_blue
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = $clog2(SCALE + 1);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS        = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] H_ONE        = HW'(1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS        = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] V_ONE        = VW'(1);
  localparam logic [SW-1:0] S_LAST       = SW'(SCALE - 1);
  localparam logic [SW-1:0] S_ONE        = SW'(1);
  localparam logic [6:0]    HPIX_MAX     = 7'((H_VISIBLE - 1) / SCALE);
  localparam logic [6:0]    VPIX_MAX     = 7'((V_VISIBLE - 1) / SCALE);

  logic          pix_en;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [SW-1:0] h_sub, h_sub_nxt, v_sub, v_sub_nxt;
  logic [6:0]    hpix_nxt, vpix_nxt;
  logic          hpix_inc, vpix_inc;
  logic          h_wrap;
  logic          hsync_nxt, vsync_nxt, de_nxt;

  // Everything is computed from the next counter values so the registered
  // outputs line up with the counters without an extra pipeline stage.
  always_comb begin
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    h_sub_nxt = h_sub;
    v_sub_nxt = v_sub;
    hpix_nxt  = hpixel;
    vpix_nxt  = vpixel;
    hpix_inc  = 1'b0;
    vpix_inc  = 1'b0;
    h_wrap    = pix_en && (h_cnt == H_LAST);

    if (pix_en) begin
      h_nxt = h_wrap ? '0 : h_cnt + H_ONE;
      if (h_nxt == '0) begin
        h_sub_nxt = '0;
        hpix_nxt  = '0;
      end else if (h_nxt < H_VIS) begin
        if (h_sub == S_LAST) begin
          h_sub_nxt = '0;
          hpix_inc  = 1'b1;
          hpix_nxt  = hpixel + 7'd1;
        end else begin
          h_sub_nxt = h_sub + S_ONE;
        end
      end
    end

    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
      if (v_nxt == '0) begin
        v_sub_nxt = '0;
        vpix_nxt  = '0;
      end else if (v_nxt < V_VIS) begin
        if (v_sub == S_LAST) begin
          v_sub_nxt = '0;
          vpix_inc  = 1'b1;
          vpix_nxt  = vpixel + 7'd1;
        end else begin
          v_sub_nxt = v_sub + S_ONE;
        end
      end
    end

    hsync_nxt = !((h_nxt >= H_SYNC_FIRST) && (h_nxt <= H_SYNC_LAST));
    vsync_nxt = !((v_nxt >= V_SYNC_FIRST) && (v_nxt <= V_SYNC_LAST));
    de_nxt    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en     <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      h_sub      <= '0;
      v_sub      <= '0;
      VGA_HSYNC  <= 1'b1;
      VGA_VSYNC  <= 1'b1;
      display_en <= 1'b0;
      new_line   <= 1'b0;
      new_frame  <= 1'b0;
      hpixel     <= '0;
      vpixel     <= '0;
    end else begin
      pix_en     <= ~pix_en;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      h_sub      <= h_sub_nxt;
      v_sub      <= v_sub_nxt;
      VGA_HSYNC  <= hsync_nxt;
      VGA_VSYNC  <= vsync_nxt;
      display_en <= de_nxt;
      new_line   <= h_wrap;
      new_frame  <= h_wrap && (v_cnt == V_LAST);
      hpixel     <= hpix_nxt;
      vpixel     <= vpix_nxt;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Eight vertical bars taken from the top bits of the framebuffer column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {pat_red, pat_green, pat_blue} <= 3'b000;
    end else begin
      {pat_red, pat_green, pat_blue} <= de_nxt ? hpix_nxt[6:4] : 3'b000;
    end
  end
`endif

  hpixel_no_overflow: assert property (@(posedge clk) disable iff (reset) hpix_inc |-> (hpixel < HPIX_MAX));
  vpixel_no_overflow: assert property (@(posedge clk) disable iff (reset) vpix_inc |-> (vpixel < VPIX_MAX));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: full-size instance for line timing, a shrunken
// instance for frame timing, random mid-run resets, reference model by plain arithmetic.
module tb_vga_timing_gen;

  localparam int SH_VIS = 40, SH_FP = 4, SH_SYNC = 6, SH_BP = 6;
  localparam int SV_VIS = 20, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
  localparam int S_FRAME_CLK = 2 * (SH_VIS + SH_FP + SH_SYNC + SH_BP) * (SV_VIS + SV_FP + SV_SYNC + SV_BP);
  localparam int S_VSYNC_CLK = 2 * SV_SYNC * (SH_VIS + SH_FP + SH_SYNC + SH_BP);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       nl;
    logic       nf;
    logic [6:0] hp;
    logic [6:0] vp;
    logic [2:0] rgb;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  logic       f_hs, f_vs, f_de, f_nl, f_nf, s_hs, s_vs, s_de, s_nl, s_nf;
  logic [6:0] f_hp, f_vp, s_hp, s_vp;
  logic [2:0] f_rgb, s_rgb;
  out_t       act_f, act_s;

  vga_timing_gen dut_full (
    .clk(clk), .reset(reset), .VGA_HSYNC(f_hs), .VGA_VSYNC(f_vs), .display_en(f_de),
    .new_line(f_nl), .new_frame(f_nf), .hpixel(f_hp), .vpixel(f_vp)
`ifdef VGA_TEST_PATTERN_EN
    , .pat_red(f_rgb[2]), .pat_green(f_rgb[1]), .pat_blue(f_rgb[0])
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SYNC), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SYNC), .V_BACK(SV_BP), .SCALE(5)
  ) dut_small (
    .clk(clk), .reset(reset), .VGA_HSYNC(s_hs), .VGA_VSYNC(s_vs), .display_en(s_de),
    .new_line(s_nl), .new_frame(s_nf), .hpixel(s_hp), .vpixel(s_vp)
`ifdef VGA_TEST_PATTERN_EN
    , .pat_red(s_rgb[2]), .pat_green(s_rgb[1]), .pat_blue(s_rgb[0])
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign f_rgb = 3'b000;
  assign s_rgb = 3'b000;
`endif

  assign act_f = {f_hs, f_vs, f_de, f_nl, f_nf, f_hp, f_vp, f_rgb};
  assign act_s = {s_hs, s_vs, s_de, s_nl, s_nf, s_hp, s_vp, s_rgb};

  int   tests = 0;
  int   fails = 0;
  out_t q_full[$];
  out_t q_small[$];
  int   n_model = 0;
  bit   prev_rst = 1'b1;

  // Outputs after n clk edges since reset release; n=0 means still in reset.
  function automatic out_t model(int n, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int sc);
    out_t e;
    int ht, vt, t, h, v;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n == 0) return e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    t = n / 2;
    h = t % ht;
    v = (t / ht) % vt;
    e.hs = !(h >= hv + hf && h < hv + hf + hsw);
    e.vs = !(v >= vv + vf && v < vv + vf + vsw);
    e.de = (h < hv) && (v < vv);
    e.nl = (n % 2 == 0) && (h == 0);
    e.nf = e.nl && (v == 0);
    e.hp = 7'(((h < hv) ? h : hv - 1) / sc);
    e.vp = 7'(((v < vv) ? v : vv - 1) / sc);
`ifdef VGA_TEST_PATTERN_EN
    e.rgb = e.de ? e.hp[6:4] : 3'b000;
`endif
    return e;
  endfunction

  task automatic check_out(string name, out_t a, out_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0t got hs=%b vs=%b de=%b nl=%b nf=%b hp=%0d vp=%0d rgb=%b expected hs=%b vs=%b de=%b nl=%b nf=%b hp=%0d vp=%0d rgb=%b",
               name, $time, a.hs, a.vs, a.de, a.nl, a.nf, a.hp, a.vp, a.rgb,
               e.hs, e.vs, e.de, e.nl, e.nf, e.hp, e.vp, e.rgb);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, a, e);
    end
  endtask

  // One clock of stimulus: drive reset at the falling edge, push the expected
  // outputs for the following rising edge.
  task automatic step(bit rst);
    out_t rv;
    @(negedge clk);
    reset = rst;
    if (rst && !prev_rst) begin
      rv = model(0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
      #1;
      check_out("async_reset_full", act_f, rv);
      check_out("async_reset_small", act_s, rv);
    end
    prev_rst = rst;
    n_model = rst ? 0 : n_model + 1;
    q_full.push_back(model(n_model, 640, 16, 96, 48, 480, 10, 2, 33, 5));
    q_small.push_back(model(n_model, SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP, 5));
  endtask

  // Monitor: compares every presented output against the scoreboard and
  // measures sync widths and strobe periods independently of the model.
  initial begin : monitor
    int   cyc, nl_last, line_start, hs_fall, nf_last, vs_fall;
    logic hs_prev, vs_prev;
    out_t e;
    cyc = 0; nl_last = -1; line_start = 0; hs_fall = -1; nf_last = -1; vs_fall = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cyc = 0; nl_last = -1; line_start = 0; hs_fall = -1; nf_last = -1; vs_fall = -1;
      end else begin
        cyc++;
      end
      if (q_full.size() > 0) begin
        e = q_full.pop_front();
        check_out("full_outputs", act_f, e);
      end
      if (q_small.size() > 0) begin
        e = q_small.pop_front();
        check_out("small_outputs", act_s, e);
      end
      if (!reset) begin
        if (f_nl) begin
          if (nl_last >= 0) check_int("new_line_period", cyc - nl_last, 1600);
          nl_last = cyc;
          line_start = cyc;
        end
        if (hs_prev && !f_hs) begin
          check_int("hsync_offset", cyc - line_start, 1312);
          hs_fall = cyc;
        end
        if (!hs_prev && f_hs && hs_fall >= 0) check_int("hsync_width", cyc - hs_fall, 192);
        if (s_nf) begin
          if (nf_last >= 0) check_int("new_frame_period", cyc - nf_last, S_FRAME_CLK);
          else check_int("first_new_frame", cyc, S_FRAME_CLK);
          check_int("frame_line_coincide", int'(s_nl), 1);
          nf_last = cyc;
        end
        if (vs_prev && !s_vs) vs_fall = cyc;
        if (!vs_prev && s_vs && vs_fall >= 0) check_int("vsync_width", cyc - vs_fall, S_VSYNC_CLK);
      end
      hs_prev = f_hs;
      vs_prev = s_vs;
    end
  end

  initial begin : stimulus
    int len;
    repeat (10) step(1'b1);
    repeat (4000) step(1'b0);
    for (int seg = 0; seg < 6; seg++) begin
      len = $urandom_range(200, 6000);
      repeat (len) step(1'b0);
      len = $urandom_range(1, 4);
      repeat (len) step(1'b1);
    end
    repeat (7000) step(1'b0);
    @(posedge clk);
    #2;
    check_int("scoreboard_drained", q_full.size() + q_small.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
